wave_gen: RTL and testbench

//  Parametrised multi-mode waveform generator: triangle, sawtooth or square on one

---
 rtl/wave_pkg.sv | 19 +
 rtl/wave_prescaler.sv | 33 +++
 rtl/wave_gen.sv | 145 ++++++++++++++
 tb/tb_wave_gen.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types for the multi-mode waveform generator (wave_gen).
package wave_pkg;

  localparam int MODE_W = 2;

  // The reserved encoding is named only so the mode register can be cast cleanly; it behaves as TRI.
  typedef enum logic [MODE_W-1:0] {
    MODE_TRI = 2'b00,
    MODE_SAW = 2'b01,
    MODE_SQR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/wave_prescaler.sv
// Tick prescaler for wave_gen: one tick every prescaler_i+1 cycles while enabled.
module wave_prescaler
  import wave_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ena_i,
  input  logic [PRESC_W-1:0] prescaler_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // Equality compare against the live port: a lowered limit below cnt_q wraps the counter.
  always_comb begin
    tick_o = ena_i && (cnt_q == prescaler_i);
    cnt_d  = cnt_q + 1'b1;
    if (!ena_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wave_gen.sv
// Triangle / sawtooth / square generator with shadowed settings and a tick prescaler.
// Optional period_tick output is built only when WAVE_TICK_EN is defined.
module wave_gen
  import wave_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [MODE_W-1:0]  mode,
  input  logic [WIDTH-1:0]   amplitude,
  input  logic [WIDTH-1:0]   step,
  input  logic [PRESC_W-1:0] prescaler,
  output logic [WIDTH-1:0]   data
`ifdef WAVE_TICK_EN
  ,
  output logic               period_tick
`endif
);

  logic tick;

  wave_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i       (clk),
    .rst_i       (rst),
    .ena_i       (ena),
    .prescaler_i (prescaler),
    .tick_o      (tick)
  );

  mode_e            mode_s_q, mode_s_d;
  logic [WIDTH-1:0] amp_s_q, amp_s_d;
  logic [WIDTH-1:0] step_s_q, step_s_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ptick_q, ptick_d;
  logic             boundary;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   sum;

  assign step_eff = (step_s_q == '0) ? WIDTH'(1) : step_s_q;
  assign sum      = {1'b0, acc_q} + {1'b0, step_eff};

  always_comb begin
    mode_s_d = mode_s_q;
    amp_s_d  = amp_s_q;
    step_s_d = step_s_q;
    acc_d    = acc_q;
    dir_d    = dir_q;
    data_d   = data_q;
    ptick_d  = 1'b0;
    boundary = 1'b0;

    if (tick) begin
      if (amp_s_q == '0) begin
        acc_d    = '0;
        dir_d    = DIR_UP;
        boundary = 1'b1;
      end else if (mode_s_q == MODE_SAW) begin
        dir_d = DIR_UP;
        if (acc_q == amp_s_q) begin
          acc_d    = '0;
          boundary = 1'b1;
        end else if (sum >= {1'b0, amp_s_q}) begin
          acc_d = amp_s_q;
        end else begin
          acc_d = sum[WIDTH-1:0];
        end
      end else if (dir_q == DIR_UP) begin
        if (sum >= {1'b0, amp_s_q}) begin
          acc_d = amp_s_q;
          dir_d = DIR_DOWN;
        end else begin
          acc_d = sum[WIDTH-1:0];
        end
      end else begin
        if (acc_q <= step_eff) begin
          acc_d    = '0;
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end else begin
          acc_d = acc_q - step_eff;
        end
      end

      // Square output follows the direction after this update, not the one before it.
      if (mode_s_q == MODE_SQR) begin
        data_d = (dir_d == DIR_UP) ? amp_s_q : '0;
      end else begin
        data_d = acc_d;
      end

      if (boundary) begin
        mode_s_d = mode_e'(mode);
        amp_s_d  = amplitude;
        step_s_d = step;
        dir_d    = DIR_UP;
        ptick_d  = 1'b1;
      end
    end

    if (!ena) begin
      mode_s_d = mode_e'(mode);
      amp_s_d  = amplitude;
      step_s_d = step;
      acc_d    = '0;
      dir_d    = DIR_UP;
      data_d   = '0;
      ptick_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_s_q <= mode_e'(mode);
      amp_s_q  <= amplitude;
      step_s_q <= step;
      acc_q    <= '0;
      dir_q    <= DIR_UP;
      data_q   <= '0;
      ptick_q  <= 1'b0;
    end else begin
      mode_s_q <= mode_s_d;
      amp_s_q  <= amp_s_d;
      step_s_q <= step_s_d;
      acc_q    <= acc_d;
      dir_q    <= dir_d;
      data_q   <= data_d;
      ptick_q  <= ptick_d;
    end
  end

  assign data = data_q;

`ifdef WAVE_TICK_EN
  assign period_tick = ptick_q;
`else
  logic unused_ptick;
  assign unused_ptick = ptick_q;
`endif

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: vector table, hand-written corner sequences and a
// randomized run against a period-list reference model.
module tb_wave_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [1:0]  mode;
  logic [15:0] amplitude;
  logic [15:0] stp;
  logic [15:0] prescaler;
  logic [15:0] data;
  logic        period_tick;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

`ifdef WAVE_TICK_EN
  wave_gen dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mode        (mode),
    .amplitude   (amplitude),
    .step        (stp),
    .prescaler   (prescaler),
    .data        (data),
    .period_tick (period_tick)
  );
`else
  wave_gen dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .mode      (mode),
    .amplitude (amplitude),
    .step      (stp),
    .prescaler (prescaler),
    .data      (data)
  );
  assign period_tick = 1'b0;
`endif

  // Reference model: one whole period is listed up front from the shadow settings,
  // then consumed one sample per tick; an emptied list marks the period boundary.
  int unsigned m_cnt;
  logic [1:0]  m_mode;
  logic [15:0] m_amp;
  logic [15:0] m_step;
  logic [15:0] m_data;
  logic        m_pt;
  logic [15:0] q_val[$];

  function automatic void gen_period(input logic [1:0] md, input logic [15:0] a16,
                                     input logic [15:0] s16);
    int a, s, v, n_up;
    int tri_q[$];
    a = int'(a16);
    s = (s16 == 16'd0) ? 1 : int'(s16);
    q_val.delete();
    if (a == 0) begin
      q_val.push_back(16'h0);
    end else if (md == 2'b01) begin
      v = 0;
      do begin
        v = (v + s >= a) ? a : v + s;
        q_val.push_back(16'(v));
      end while (v != a);
      q_val.push_back(16'h0);
    end else begin
      v = 0;
      n_up = 0;
      while (v + s < a) begin
        v += s;
        tri_q.push_back(v);
        n_up++;
      end
      tri_q.push_back(a);
      v = a;
      while (v > s) begin
        v -= s;
        tri_q.push_back(v);
      end
      tri_q.push_back(0);
      for (int i = 0; i < tri_q.size(); i++) begin
        if (md == 2'b10) q_val.push_back((i < n_up || i == tri_q.size() - 1) ? a16 : 16'h0);
        else             q_val.push_back(16'(tri_q[i]));
      end
    end
  endfunction

  task automatic model_step();
    if (rst || !ena) begin
      m_cnt  = 0;
      q_val.delete();
      m_mode = mode;
      m_amp  = amplitude;
      m_step = stp;
      m_data = 16'h0;
      m_pt   = 1'b0;
    end else if (m_cnt == int'(prescaler)) begin
      m_cnt = 0;
      if (q_val.size() == 0) gen_period(m_mode, m_amp, m_step);
      m_data = q_val.pop_front();
      m_pt   = (q_val.size() == 0);
      if (m_pt) begin
        m_mode = mode;
        m_amp  = amplitude;
        m_step = stp;
      end
    end else begin
      m_cnt = (m_cnt + 1) & 32'hFFFF;
      m_pt  = 1'b0;
    end
  endtask

  // One clock: the model sees the same inputs as the DUT at the edge; checks follow on negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input logic [1:0] md, input logic [15:0] a, input logic [15:0] s,
                      input logic [15:0] p);
    ena = 1'b0;
    mode = md;
    amplitude = a;
    stp = s;
    prescaler = p;
    cycle();
    cycle();
    chk("idle_data", data, 16'h0);
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [15:0] amp;
    logic [15:0] st;
    logic [15:0] pr;
    logic [15:0] exp [12];
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2'b00, 16'd4, 16'd1, 16'd0,
                '{16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4}};
    vecs[1] = '{2'b01, 16'd10, 16'd3, 16'd1,
                '{16'd0, 16'd3, 16'd3, 16'd6, 16'd6, 16'd9, 16'd9, 16'd10, 16'd10, 16'd0, 16'd0, 16'd3}};
    vecs[2] = '{2'b10, 16'hFFFF, 16'h4000, 16'd0,
                '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF,
                  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0}};
    vecs[3] = '{2'b11, 16'd2, 16'd0, 16'd0,
                '{16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 16'd1, 16'd0}};
    vecs[4] = '{2'b01, 16'd0, 16'd0, 16'd2,
                '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}};
    vecs[5] = '{2'b01, 16'd5, 16'd2, 16'd0,
                '{16'd2, 16'd4, 16'd5, 16'd0, 16'd2, 16'd4, 16'd5, 16'd0, 16'd2, 16'd4, 16'd5, 16'd0}};
    vecs[6] = '{2'b00, 16'd5, 16'd3, 16'd0,
                '{16'd3, 16'd5, 16'd2, 16'd0, 16'd3, 16'd5, 16'd2, 16'd0, 16'd3, 16'd5, 16'd2, 16'd0}};

    rst = 1'b1;
    ena = 1'b0;
    mode = 2'b00;
    amplitude = 16'd4;
    stp = 16'd1;
    prescaler = 16'd0;
    cycle();
    cycle();
    chk("reset_data", data, 16'h0);
`ifdef WAVE_TICK_EN
    chk("reset_ptick", {15'h0, period_tick}, 16'h0);
`endif
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      idle(vecs[v].md, vecs[v].amp, vecs[v].st, vecs[v].pr);
      ena = 1'b1;
      for (int k = 0; k < 12; k++) begin
        cycle();
        chk($sformatf("vec%0d_s%0d", v, k), data, vecs[v].exp[k]);
      end
    end

    // Amplitude raised mid-period: the old period finishes before the new peak shows.
    idle(2'b00, 16'd4, 16'd1, 16'd0);
    ena = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    chk("amp_chg_pre", data, 16'd3);
    amplitude = 16'd8;
    begin
      logic [15:0] exp_seq [13];
      exp_seq = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 16'd3,
                  16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
      for (int k = 0; k < 13; k++) begin
        cycle();
        chk($sformatf("amp_chg_s%0d", k), data, exp_seq[k]);
      end
    end

    // ena dropped and rst asserted mid-ramp, then restarted.
    for (int k = 0; k < 2; k++) cycle();
    ena = 1'b0;
    cycle();
    chk("ena_drop", data, 16'd0);
    ena = 1'b1;
    cycle();
    chk("ena_restart", data, 16'd1);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_mid", data, 16'd0);
    rst = 1'b0;
    cycle();
    chk("rst_restart", data, 16'd1);

    // amp=0 with step=0: output held at 0, every tick closes a period.
    idle(2'b00, 16'd0, 16'd0, 16'd0);
    ena = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("amp0_s%0d", k), data, 16'd0);
`ifdef WAVE_TICK_EN
      chk($sformatf("amp0_pt%0d", k), {15'h0, period_tick}, 16'h1);
`endif
    end

    // Randomized run against the reference model.
    idle(2'b00, 16'd6, 16'd1, 16'd1);
    ena = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      int unsigned r;
      cycle();
      chk("rand_data", data, m_data);
`ifdef WAVE_TICK_EN
      chk("rand_ptick", {15'h0, period_tick}, {15'h0, m_pt});
`endif
      r = $urandom_range(0, 999);
      rst = (r < 5);
      if (r >= 5 && r < 25) begin
        ena = ~ena;
        if (!ena) prescaler = 16'($urandom_range(0, 3));
      end
      if (r >= 25 && r < 75) begin
        mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) begin
          amplitude = 16'hFFFF - 16'($urandom_range(0, 15));
          stp = 16'($urandom_range(16'h1000, 16'h7000));
        end else begin
          amplitude = 16'($urandom_range(0, 24));
          stp = 16'($urandom_range(0, 6));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
